// File: rtl/slurm_core_if.sv
// ============================================================================
// Module   : slurm_core_if
// Purpose  : Word-addressed single-port memory bus between the core and memory.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface slurm_core_if #(
    parameter int BITS = 16
);
    logic            mem_req;
    logic            mem_we;
    logic [BITS-1:0] mem_addr;
    logic [BITS-1:0] mem_wdata;
    logic [BITS-1:0] mem_rdata;
    logic            mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

`default_nettype wire

// File: rtl/slurm_core.sv
// ============================================================================
// Module   : slurm_core
// Purpose  : Multicycle 16-bit-instruction core (FETCH/EXEC/MEM/HALT).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module slurm_core #(
    parameter int          BITS     = 16,
    parameter int          REG_BITS = 3,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  wire logic        CLK,
    input  wire logic        RST,
    slurm_core_if.master     bus,
    output logic             halted,
    output logic [2:0]       flags
);
    localparam int NREGS = 2 ** REG_BITS;

    localparam logic [3:0] c_OP_MOVI = 4'h1;
    localparam logic [3:0] c_OP_ADD  = 4'h2;
    localparam logic [3:0] c_OP_SUB  = 4'h3;
    localparam logic [3:0] c_OP_AND  = 4'h4;
    localparam logic [3:0] c_OP_OR   = 4'h5;
    localparam logic [3:0] c_OP_XOR  = 4'h6;
    localparam logic [3:0] c_OP_LD   = 4'h7;
    localparam logic [3:0] c_OP_ST   = 4'h8;
    localparam logic [3:0] c_OP_BZ   = 4'h9;
    localparam logic [3:0] c_OP_JMP  = 4'hA;
    localparam logic [3:0] c_OP_HALT = 4'hB;

    localparam logic [BITS-1:0] c_ONE      = {{(BITS-1){1'b0}}, 1'b1};
    localparam logic [BITS-1:0] c_RESET_PC = RESET_PC[BITS-1:0];

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state_q;
    logic [BITS-1:0]   pc_q;
    logic [15:0]       ir_q;
    logic [BITS-1:0]   regs_q [NREGS];
    logic [2:0]        flags_q;
    logic              halted_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [BITS-1:0]   mem_addr_q;
    logic [BITS-1:0]   mem_wdata_q;

    logic [3:0]          op;
    logic [REG_BITS-1:0] rd_idx;
    logic [REG_BITS-1:0] ra_idx;
    logic [REG_BITS-1:0] rb_idx;
    logic [BITS-1:0]     opa;
    logic [BITS-1:0]     opb;
    logic [BITS-1:0]     opd;
    logic [BITS-1:0]     imm_sext;
    logic [BITS-1:0]     res_d;
    logic                carry_d;
    logic [BITS-1:0]     pc_d;
    logic                w_unused_ir;

    assign op       = ir_q[15:12];
    assign rd_idx   = ir_q[8 +: REG_BITS];
    assign ra_idx   = ir_q[4 +: REG_BITS];
    assign rb_idx   = ir_q[0 +: REG_BITS];
    assign opa      = regs_q[ra_idx];
    assign opb      = regs_q[rb_idx];
    assign opd      = regs_q[rd_idx];
    assign imm_sext = {{(BITS-8){ir_q[7]}}, ir_q[7:0]};
    assign w_unused_ir = &{1'b0, ir_q};

    // SUB borrow falls out of the (BITS+1)-bit difference: top bit set iff opa < opb.
    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        case (op)
            c_OP_ADD: {carry_d, res_d} = {1'b0, opa} + {1'b0, opb};
            c_OP_SUB: {carry_d, res_d} = {1'b0, opa} - {1'b0, opb};
            c_OP_AND: res_d = opa & opb;
            c_OP_OR:  res_d = opa | opb;
            c_OP_XOR: res_d = opa ^ opb;
            default:  res_d = '0;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (op == c_OP_BZ && flags_q[1]) begin
            pc_d = pc_q + imm_sext;
        end else if (op == c_OP_JMP) begin
            pc_d = opa;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_FETCH;
            pc_q        <= c_RESET_PC;
            ir_q        <= '0;
            flags_q     <= 3'b000;
            halted_q    <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= c_RESET_PC;
            mem_wdata_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        ir_q      <= bus.mem_rdata[15:0];
                        pc_q      <= pc_q + c_ONE;
                        mem_req_q <= 1'b0;
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_q    <= S_FETCH;
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= pc_d;
                    pc_q       <= pc_d;
                    case (op)
                        c_OP_MOVI: regs_q[rd_idx] <= imm_sext;
                        c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR: begin
                            regs_q[rd_idx] <= res_d;
                            flags_q        <= {res_d[BITS-1], (res_d == '0), carry_d};
                        end
                        c_OP_LD, c_OP_ST: begin
                            state_q     <= S_MEM;
                            mem_we_q    <= (op == c_OP_ST);
                            mem_addr_q  <= opa;
                            mem_wdata_q <= opd;
                        end
                        c_OP_HALT: begin
                            state_q   <= S_HALT;
                            mem_req_q <= 1'b0;
                            halted_q  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        if (!mem_we_q) begin
                            regs_q[rd_idx] <= bus.mem_rdata;
                        end
                        state_q    <= S_FETCH;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                    end
                end
                S_HALT: begin
                    mem_req_q <= 1'b0;
                    halted_q  <= 1'b1;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign halted        = halted_q;
    assign flags         = flags_q;
endmodule

`default_nettype wire

// File: tb/tb_slurm_core.sv
// ============================================================================
// Module   : tb_slurm_core
// Purpose  : Directed programs against a 16-bit and a 32-bit core instance.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_slurm_core;
    logic        clk = 1'b0;
    logic        rst16 = 1'b1;
    logic        rst32 = 1'b1;
    logic        halted16, halted32;
    logic [2:0]  flags16, flags32;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem16 [256];
    logic [31:0] mem32 [256];
    int          ws16 = 0, ws32 = 0;
    int          cnt16 = 0, cnt32 = 0;
    int          stab16 = 0, wr16 = 0;
    logic [15:0] lastwa16 = '0;
    logic        pw16 = 1'b0, pwe16 = 1'b0;
    logic [15:0] pa16 = '0, pd16 = '0;

    slurm_core_if #(.BITS(16)) bus16 ();
    slurm_core_if #(.BITS(32)) bus32 ();

    slurm_core #(.BITS(16), .REG_BITS(3), .RESET_PC(32'd0)) dut16 (
        .CLK(clk), .RST(rst16), .bus(bus16), .halted(halted16), .flags(flags16)
    );

    slurm_core #(.BITS(32), .REG_BITS(4), .RESET_PC(32'hFFFF_FFFE)) dut32 (
        .CLK(clk), .RST(rst32), .bus(bus32), .halted(halted32), .flags(flags32)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear16();
        for (int i = 0; i < 256; i++) mem16[i] = 16'hB000;
    endtask

    task automatic reset16();
        rst16 = 1'b1;
        repeat (2) @(negedge clk);
        rst16 = 1'b0;
    endtask

    task automatic wait_halt16(input string tag, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (halted16) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    // 16-bit memory: ws16 wait states per access; logs writes and bus stability during waits.
    initial begin
        bus16.mem_ready = 1'b0;
        bus16.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pw16 && bus16.mem_req &&
                (bus16.mem_addr !== pa16 || bus16.mem_we !== pwe16 ||
                 (bus16.mem_we && bus16.mem_wdata !== pd16)))
                stab16++;
            if (bus16.mem_req) begin
                if (cnt16 >= ws16) begin
                    bus16.mem_ready = 1'b1;
                    bus16.mem_rdata = mem16[bus16.mem_addr[7:0]];
                    if (bus16.mem_we) begin
                        mem16[bus16.mem_addr[7:0]] = bus16.mem_wdata;
                        lastwa16 = bus16.mem_addr;
                        wr16++;
                    end
                    cnt16 = 0;
                end else begin
                    bus16.mem_ready = 1'b0;
                    cnt16++;
                end
            end else begin
                bus16.mem_ready = 1'b0;
                cnt16 = 0;
            end
            pw16  = bus16.mem_req && !bus16.mem_ready;
            pa16  = bus16.mem_addr;
            pwe16 = bus16.mem_we;
            pd16  = bus16.mem_wdata;
        end
    end

    initial begin
        bus32.mem_ready = 1'b0;
        bus32.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus32.mem_req) begin
                if (cnt32 >= ws32) begin
                    bus32.mem_ready = 1'b1;
                    bus32.mem_rdata = mem32[bus32.mem_addr[7:0]];
                    if (bus32.mem_we) mem32[bus32.mem_addr[7:0]] = bus32.mem_wdata;
                    cnt32 = 0;
                end else begin
                    bus32.mem_ready = 1'b0;
                    cnt32++;
                end
            end else begin
                bus32.mem_ready = 1'b0;
                cnt32 = 0;
            end
        end
    end

    initial begin
        bit found;

        // MOVI/MOVI/ADD/HALT, zero wait states: halted exactly 8 cycles after reset.
        clear16();
        mem16[0] = 16'h1105; mem16[1] = 16'h1203; mem16[2] = 16'h2312; mem16[3] = 16'hB000;
        ws16 = 0;
        reset16();
        check("rst_req", {31'd0, bus16.mem_req}, 32'd1);
        check("rst_addr", {16'd0, bus16.mem_addr}, 32'd0);
        check("rst_we", {31'd0, bus16.mem_we}, 32'd0);
        check("rst_halted", {31'd0, halted16}, 32'd0);
        check("rst_flags", {29'd0, flags16}, 32'd0);
        cyc(7);
        check("a_halted_c7", {31'd0, halted16}, 32'd0);
        cyc(1);
        check("a_halted_c8", {31'd0, halted16}, 32'd1);
        check("a_r3", {16'd0, dut16.regs_q[3]}, 32'd8);
        check("a_flags", {29'd0, flags16}, 32'd0);
        check("a_halt_req", {31'd0, bus16.mem_req}, 32'd0);
        cyc(3);
        check("a_halt_stay", {31'd0, halted16}, 32'd1);

        // Carry on ADD wrap to zero, borrow on SUB.
        clear16();
        mem16[0] = 16'h11FF; mem16[1] = 16'h1201; mem16[2] = 16'h2312;
        mem16[3] = 16'h3421; mem16[4] = 16'hB000;
        reset16();
        cyc(6);
        check("b_add_flags", {29'd0, flags16}, 32'b011);
        check("b_r3", {16'd0, dut16.regs_q[3]}, 32'd0);
        cyc(2);
        check("b_sub_flags", {29'd0, flags16}, 32'b001);
        check("b_r4", {16'd0, dut16.regs_q[4]}, 32'd2);
        cyc(2);
        check("b_halted", {31'd0, halted16}, 32'd1);

        // Logic ops clear C; ADD r1,r1,r1 reads before write.
        clear16();
        mem16[0] = 16'h1180; mem16[1] = 16'h120F; mem16[2] = 16'h6312; mem16[3] = 16'h4412;
        mem16[4] = 16'h5512; mem16[5] = 16'h2111; mem16[6] = 16'hB000;
        reset16();
        cyc(6);
        check("c_xor_flags", {29'd0, flags16}, 32'b100);
        cyc(2);
        check("c_and_flags", {29'd0, flags16}, 32'b010);
        cyc(2);
        check("c_or_flags", {29'd0, flags16}, 32'b100);
        cyc(2);
        check("c_add_flags", {29'd0, flags16}, 32'b101);
        check("c_r1", {16'd0, dut16.regs_q[1]}, 32'hFF00);
        check("c_r3", {16'd0, dut16.regs_q[3]}, 32'hFF8F);
        check("c_r4", {16'd0, dut16.regs_q[4]}, 32'h0000);
        check("c_r5", {16'd0, dut16.regs_q[5]}, 32'hFF8F);

        // ST then LD through 3 wait states per access.
        clear16();
        mem16[0] = 16'h115A; mem16[1] = 16'h1240; mem16[2] = 16'h8120;
        mem16[3] = 16'h7520; mem16[4] = 16'hB000;
        ws16 = 3;
        stab16 = 0;
        wr16 = 0;
        reset16();
        wait_halt16("d_halt_timeout", 200);
        check("d_mem40", {16'd0, mem16[8'h40]}, 32'h005A);
        check("d_waddr", {16'd0, lastwa16}, 32'h0040);
        check("d_wcount", wr16, 32'd1);
        check("d_r5", {16'd0, dut16.regs_q[5]}, 32'h005A);
        check("d_stable", stab16, 32'd0);

        // BZ taken back to SUB; BZ not taken falls through; JMP.
        clear16();
        mem16[0] = 16'h3011; mem16[1] = 16'h90FE;
        ws16 = 0;
        reset16();
        cyc(4);
        check("e_bz_addr1", {16'd0, bus16.mem_addr}, 32'd0);
        check("e_bz_flags", {29'd0, flags16}, 32'b010);
        cyc(4);
        check("e_bz_addr2", {16'd0, bus16.mem_addr}, 32'd0);
        clear16();
        mem16[0] = 16'h1101; mem16[1] = 16'h2210; mem16[2] = 16'h90FD;
        mem16[3] = 16'h1320; mem16[4] = 16'hA030; mem16[8'h20] = 16'hB000;
        reset16();
        cyc(6);
        check("e_bz_fall", {16'd0, bus16.mem_addr}, 32'd3);
        cyc(4);
        check("e_jmp_addr", {16'd0, bus16.mem_addr}, 32'h20);
        cyc(2);
        check("e_jmp_halt", {31'd0, halted16}, 32'd1);

        // Reset while an LD is waiting for mem_ready.
        clear16();
        mem16[0] = 16'h11FF; mem16[1] = 16'h2311; mem16[2] = 16'h1240;
        mem16[3] = 16'h7520; mem16[4] = 16'hB000; mem16[8'h40] = 16'h1234;
        ws16 = 3;
        reset16();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus16.mem_req && !bus16.mem_we && bus16.mem_addr == 16'h0040) begin
                found = 1'b1;
                break;
            end
        end
        check("f_ld_seen", {31'd0, found}, 32'd1);
        check("f_pre_flags", {29'd0, flags16}, 32'b101);
        cyc(1);
        rst16 = 1'b1;
        cyc(1);
        rst16 = 1'b0;
        check("f_req", {31'd0, bus16.mem_req}, 32'd1);
        check("f_addr", {16'd0, bus16.mem_addr}, 32'd0);
        check("f_we", {31'd0, bus16.mem_we}, 32'd0);
        check("f_flags", {29'd0, flags16}, 32'd0);
        check("f_r1", {16'd0, dut16.regs_q[1]}, 32'd0);
        check("f_r2", {16'd0, dut16.regs_q[2]}, 32'd0);
        check("f_r5", {16'd0, dut16.regs_q[5]}, 32'd0);

        // 32-bit instance: sign extension into r15 and PC wrap.
        for (int i = 0; i < 256; i++) mem32[i] = 32'h0000_B000;
        mem32[8'hFE] = 32'h0000_1F80; mem32[8'hFF] = 32'h0000_0000; mem32[8'h00] = 32'h0000_B000;
        ws32 = 0;
        rst32 = 1'b1;
        cyc(2);
        rst32 = 1'b0;
        check("g_addr0", bus32.mem_addr, 32'hFFFF_FFFE);
        cyc(2);
        check("g_addr1", bus32.mem_addr, 32'hFFFF_FFFF);
        check("g_r15", dut32.regs_q[15], 32'hFFFF_FF80);
        check("g_flags", {29'd0, flags32}, 32'd0);
        cyc(2);
        check("g_wrap", bus32.mem_addr, 32'd0);
        cyc(2);
        check("g_halted", {31'd0, halted32}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/slurm_core.md
SLURM_CORE -- requirements
Module: slurm_core

Interface
REQ-001 SHALL have parameter BITS, default 16, meaning data, register, PC and address width (legal range 16..32).
REQ-002 SHALL have parameter REG_BITS, default 3, meaning register index width; 2**REG_BITS registers (legal range 1..4).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC value after reset.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port CLK  input  1  clock, all state on rising edge.
REQ-006 SHALL have port RST  input  1  synchronous active-high reset.
REQ-007 SHALL have port mem_req  output  1  memory access request, held until accepted.
REQ-008 SHALL have port mem_we  output  1  1 = write, 0 = read, valid while mem_req.
REQ-009 SHALL have port mem_addr  output  BITS  word address, valid while mem_req.
REQ-010 SHALL have port mem_wdata  output  BITS  store data, valid while mem_req&mem_we.
REQ-011 SHALL have port mem_rdata  input  BITS  read data, sampled when mem_ready.
REQ-012 SHALL have port mem_ready  input  1  access complete this cycle.
REQ-013 SHALL have port halted  output  1  core in HALT state.
REQ-014 SHALL have port flags  output  3  {S,Z,C} current flag register.

Function
REQ-015 SHALL be a multicycle core: FSM states FETCH, EXEC, MEM, HALT.
REQ-016 SHALL use 16-bit instructions taken from mem_rdata[15:0]: op=[15:12], rd=[11:8], ra=[7:4], rb=[3:0], imm8=[7:0]; register fields use low REG_BITS bits only.
REQ-017 SHALL in FETCH assert mem_req=1, mem_we=0, mem_addr=PC; on mem_ready latch IR, PC<=PC+1 (mod 2**BITS), go EXEC.
REQ-018 SHALL hold mem_req and all mem_* outputs stable while mem_ready=0 (unbounded wait states).
REQ-019 SHALL decode ops: 0 NOP; 1 MOVI rd<=sext(imm8); 2 ADD; 3 SUB; 4 AND; 5 OR; 6 XOR (rd<=ra op rb); 7 LD rd<=mem[ra]; 8 ST mem[ra]<=rd; 9 BZ if Z then PC<=PC+sext(imm8); A JMP PC<=ra; B HALT; C..F treated as NOP.
REQ-020 SHALL complete non-memory ops in EXEC in one cycle and return to FETCH; instruction latency = fetch wait + 2 cycles minimum.
REQ-021 SHALL for LD/ST go EXEC->MEM, drive request in MEM; LD writes rd on mem_ready; then FETCH; minimum latency 3 cycles.
REQ-022 SHALL update flags only on ADD/SUB/AND/OR/XOR: Z=(result==0), S=result[BITS-1]; C=carry-out for ADD, borrow (ra<rb unsigned) for SUB, 0 for logic ops.
REQ-023 SHALL compute arithmetic modulo 2**BITS; BZ offset is relative to already-incremented PC.
REQ-024 SHALL allow rd==ra==rb; operands read before write in same EXEC cycle.
REQ-025 SHALL in HALT keep halted=1, mem_req=0, and stay until RST.
REQ-026 SHALL deassert mem_req in EXEC and HALT.

Reset
REQ-027 SHALL on RST=1 at a clock edge, in any state including mid-access with mem_req pending, set state=FETCH, PC=RESET_PC, flags=0, all registers=0, halted=0; abandoned access is not completed.
REQ-028 SHALL drive mem_req=0 in the cycle RST is asserted is not required; mem_req SHALL be 1 with mem_addr=RESET_PC in the first cycle after RST deasserts.

Verification
REQ-029 SHALL pass: program MOVI r1,5; MOVI r2,3; ADD r3,r1,r2; HALT with mem_ready=1 -> r3=8, flags=000, halted=1 after 8 cycles.
REQ-030 SHALL pass: BITS=16, MOVI r1,-1; MOVI r2,1; ADD r3,r1,r2 -> r3=0, Z=1, C=1, S=0; SUB r4,r2,r1 -> C=1 (borrow).
REQ-031 SHALL pass: ST r1 to [r2=0x40] then LD r5,[r2] with 3 wait states per access -> mem_addr/mem_wdata stable through waits, r5=r1.
REQ-032 SHALL pass: SUB r0,r1,r1 then BZ -2 -> PC reloads to BZ address (loop); BZ with Z=0 -> falls through.
REQ-033 SHALL pass: RST asserted during LD wait state -> next cycle after release mem_req=1, mem_addr=RESET_PC, mem_we=0, registers cleared.
REQ-034 SHALL pass: BITS=32, REG_BITS=4, MOVI r15,0x80 -> r15=0xFFFFFF80, S unaffected; PC wraps 0xFFFFFFFF->0 on fetch.
